// File: rtl/mem_seq.sv
// mem_seq: load/store sequencer between the decoder/ALU and a handshaked word memory.
// Aligns store lanes, extends load results, aborts on misalignment or missing ack.
module mem_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    output logic        mem_req,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        err
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              start;
    logic              is_store;
    logic              misaligned;
    logic              launch;
    logic              abort_mis;
    logic              timeout_hit;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [4:0]        shamt_in;
    logic [4:0]        shamt_q;
    logic [3:0]        we_c;
    logic [DATA_W-1:0] wdata_c;
    logic [2:0]        f3_q;
    logic              store_q;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] ld_ext;

    // Request decode; a store wins when the decoder raises both strobes.
    assign start    = mem_rd | mem_wr;
    assign is_store = mem_wr;
    assign shamt_in = {addr[1:0], 3'b000};

    always_comb begin
        misaligned = 1'b0;
        unique case (funct3)
            3'b010:         misaligned = (addr[1:0] != 2'b00);
            3'b001, 3'b101: misaligned = addr[0];
            default:        misaligned = 1'b0;
        endcase
    end

    // Store lane enables and lane-aligned data.
    always_comb begin
        we_c = 4'b0000;
        unique case (funct3[1:0])
            2'b00:   we_c = 4'b0001 << addr[1:0];
            2'b01:   we_c = 4'b0011 << addr[1:0];
            2'b10:   we_c = 4'b1111;
            default: we_c = 4'b0000;
        endcase
    end

    assign wdata_c = rs2_data << shamt_in;

    // Load extraction from the returned word using the latched offset and type.
    assign word = mem_rdata >> shamt_q;

    always_comb begin
        ld_ext = '0;
        unique case (f3_q)
            3'b000:  ld_ext = {{24{word[7]}}, word[7:0]};
            3'b001:  ld_ext = {{16{word[15]}}, word[15:0]};
            3'b010:  ld_ext = word;
            3'b100:  ld_ext = {24'h000000, word[7:0]};
            3'b101:  ld_ext = {16'h0000, word[15:0]};
            default: ld_ext = '0;
        endcase
    end

    assign cnt_inc     = cnt + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a start seen in DONE belongs to the finishing instruction.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && !misaligned) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; stall is combinational so the PC freezes in the launch cycle.
    always_comb begin
        stall     = 1'b0;
        launch    = 1'b0;
        abort_mis = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        abort_mis = 1'b1;
                    end else begin
                        launch = 1'b1;
                        stall  = 1'b1;
                    end
                end
            end
            REQ:     stall = 1'b1;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
        if (!rst) begin
            stall = 1'b0;
        end
    end

    // Registered memory interface, counter and result path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ld_data   <= '0;
            ld_valid  <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            shamt_q   <= '0;
            f3_q      <= '0;
            store_q   <= 1'b0;
        end else begin
            ld_valid <= 1'b0;
            err      <= abort_mis;
            case (state)
                IDLE: begin
                    if (launch) begin
                        mem_req   <= 1'b1;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_we    <= is_store ? we_c : 4'b0000;
                        mem_wdata <= is_store ? wdata_c : '0;
                        shamt_q   <= shamt_in;
                        f3_q      <= funct3;
                        store_q   <= is_store;
                        cnt       <= '0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        if (!store_q) begin
                            ld_data  <= ld_ext;
                            ld_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        err     <= 1'b1;
                        ld_data <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: table-driven bench for mem_seq; expected results queue up at issue
// and are popped when the sequencer completes or rejects the access.
module tb_mem_seq;

    localparam int unsigned TMO = 15;
    localparam int unsigned NV  = 18;

    logic        clk;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] rs2_data;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        err;

    mem_seq #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .funct3    (funct3),
        .addr      (addr),
        .rs2_data  (rs2_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int unsigned ack_dly;
        logic        mis;
        logic [31:0] maddr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        ldv;
        logic [31:0] ldd;
    } vec_t;

    typedef struct {
        logic        ldv;
        logic [31:0] ldd;
        logic        er;
        int unsigned nreq;
    } res_t;

    vec_t        vecs [NV];
    res_t        exp_q [$];
    int unsigned n_run  = 0;
    int unsigned n_fail = 0;
    logic [31:0] last_ld = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        funct3   = 3'b000;
        addr     = 32'h0;
        rs2_data = 32'h0;
    endtask

    // One complete access: launch, REQ phase with ack after ack_dly cycles, DONE, back to IDLE.
    task automatic run_op(input vec_t v);
        res_t        e;
        int unsigned nreq;
        if (v.mis)
            e = '{1'b0, last_ld, 1'b1, 0};
        else if (v.ack_dly >= TMO)
            e = '{1'b0, 32'h0, 1'b1, TMO};
        else
            e = '{v.ldv, v.wr ? last_ld : v.ldd, 1'b0, v.ack_dly + 1};
        exp_q.push_back(e);

        mem_rd   = v.rd;
        mem_wr   = v.wr;
        funct3   = v.f3;
        addr     = v.addr;
        rs2_data = v.rs2;
        mem_ack  = 1'b0;
        #1;
        chk("stall_launch", 32'(stall), 32'(!v.mis));
        tick();

        if (v.mis) begin
            e = exp_q.pop_front();
            chk("mis_err", 32'(err), 32'(e.er));
            chk("mis_req", 32'(mem_req), 32'd0);
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_ldv", 32'(ld_valid), 32'd0);
            chk("mis_ldd", ld_data, e.ldd);
            idle_inputs();
            tick();
            chk("mis_err_pulse", 32'(err), 32'd0);
            chk("mis_req_after", 32'(mem_req), 32'd0);
            return;
        end

        chk("req_addr", mem_addr, v.maddr);
        chk("req_we", 32'(mem_we), 32'(v.we));
        chk("req_wdata", mem_wdata, v.wdata);
        nreq = 0;
        for (int k = 0; k < 40; k++) begin
            if (!mem_req) break;
            nreq++;
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_addr_hold", mem_addr, v.maddr);
            mem_rdata = v.rdata;
            mem_ack   = (k == int'(v.ack_dly));
            tick();
            mem_ack = 1'b0;
        end
        chk("req_bound", 32'(mem_req), 32'd0);

        e = exp_q.pop_front();
        chk("done_nreq", nreq, e.nreq);
        chk("done_ldv", 32'(ld_valid), 32'(e.ldv));
        chk("done_ldd", ld_data, e.ldd);
        chk("done_err", 32'(err), 32'(e.er));
        chk("done_stall", 32'(stall), 32'd0);

        // Stray ack in DONE with start still held: both must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = ~v.rdata;
        tick();
        mem_ack = 1'b0;
        chk("post_req", 32'(mem_req), 32'd0);
        chk("post_ldv", 32'(ld_valid), 32'd0);
        chk("post_err", 32'(err), 32'd0);
        chk("post_ldd_hold", ld_data, e.ldd);
        idle_inputs();
        last_ld = e.ldd;
    endtask

    initial begin
        //           rd    wr    f3      addr          rs2           rdata         dly mis   maddr         we       wdata         ldv   ldd
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h00000104, 32'h0,        32'hDEADBEEF, 1,  1'b0, 32'h00000104, 4'b0000, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h00000103, 32'h0,        32'h80FF1234, 0,  1'b0, 32'h00000100, 4'b0000, 32'h0,        1'b1, 32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h00000103, 32'h0,        32'h80FF1234, 0,  1'b0, 32'h00000100, 4'b0000, 32'h0,        1'b1, 32'h00000080};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h00000102, 32'h0,        32'h80FF1234, 0,  1'b0, 32'h00000100, 4'b0000, 32'h0,        1'b1, 32'h000080FF};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h00000102, 32'h0,        32'h80FF1234, 2,  1'b0, 32'h00000100, 4'b0000, 32'h0,        1'b1, 32'hFFFF80FF};
        vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h00000100, 32'h0,        32'h80FF1234, 0,  1'b0, 32'h00000100, 4'b0000, 32'h0,        1'b1, 32'h00000034};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h00000022, 32'h0000ABCD, 32'h0,        0,  1'b0, 32'h00000020, 4'b1100, 32'hABCD0000, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 3'b000, 32'h00000001, 32'h000000A5, 32'h0,        2,  1'b0, 32'h00000000, 4'b0010, 32'h0000A500, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h00000008, 32'h12345678, 32'h0,        0,  1'b0, 32'h00000008, 4'b1111, 32'h12345678, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h00000003, 32'h11223344, 32'h0,        1,  1'b0, 32'h00000000, 4'b1000, 32'h44000000, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h00000002, 32'h0,        32'h0,        0,  1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h00000005, 32'h0,        32'h0,        0,  1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b101, 32'h00000007, 32'h0,        32'h0,        0,  1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 3'b001, 32'h00000003, 32'hFFFF0000, 32'h0,        0,  1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h00000040, 32'h0,        32'h13572468, 20, 1'b0, 32'h00000040, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0,        32'hCAFEF00D, 14, 1'b0, 32'h00000010, 4'b0000, 32'h0,        1'b1, 32'hCAFEF00D};
        vecs[16] = '{1'b1, 1'b0, 3'b011, 32'h00000000, 32'h0,        32'hFFFFFFFF, 0,  1'b0, 32'h00000000, 4'b0000, 32'h0,        1'b1, 32'h00000000};
        vecs[17] = '{1'b1, 1'b0, 3'b001, 32'h00000100, 32'h0,        32'h12348001, 0,  1'b0, 32'h00000100, 4'b0000, 32'h0,        1'b1, 32'hFFFF8001};

        rst       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        idle_inputs();
        tick();
        tick();

        // Stall forced low while reset is held, even with a request pending.
        mem_rd = 1'b1;
        funct3 = 3'b010;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_ldd", ld_data, 32'h0);
        chk("rst_ldv", 32'(ld_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        idle_inputs();
        rst = 1'b1;
        tick();

        for (int i = 0; i < int'(NV); i++) begin
            run_op(vecs[i]);
        end

        // Reset on the second REQ cycle aborts silently; a late ack is ignored.
        mem_rd = 1'b1;
        funct3 = 3'b010;
        addr   = 32'h00000040;
        tick();
        tick();
        chk("mid_in_req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        tick();
        rst = 1'b1;
        chk("mid_req", 32'(mem_req), 32'd0);
        chk("mid_stall", 32'(stall), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_ldv", 32'(ld_valid), 32'd0);
        chk("mid_ldd", ld_data, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_ldv", 32'(ld_valid), 32'd0);
        chk("late_ack_err", 32'(err), 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        tick();
        chk("late_ack_ldd", ld_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
